// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   Memory-mapped I/O bridge between a simple 16-bit processor bus and a
//   synchronous data RAM, the board LEDs/switches, and a prescaled 16-bit
//   timer. Reads return data one cycle after the address is presented.
//
//   Region map (addr[15:12]):
//     0x0 RAM | 0x1 LED | 0x3 SW | 0x4 TCOUNT | 0x5 TCTRL | others unmapped
//
// Ports
//   Clock        system clock, rising edge
//   Resetn       asynchronous active-low reset
//   addr         processor address
//   dout         processor write data
//   w            one-cycle write strobe
//   DATA         read data to the processor bus mux
//   ram_address  RAM address (truncated addr)
//   ram_data     RAM write data
//   ram_wren     RAM write enable
//   ram_q        RAM read data, one cycle after ram_address
//   SW           asynchronous board switches
//   LEDR         board LEDs
module mem_io_bridge #(
  parameter int RAM_AW   = 8,
  parameter int PRESCALE = 50000
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [15:0]       addr,
  input  logic [15:0]       dout,
  input  logic              w,
  output logic [15:0]       DATA,
  output logic [RAM_AW-1:0] ram_address,
  output logic [15:0]       ram_data,
  output logic              ram_wren,
  input  logic [15:0]       ram_q,
  input  logic [9:0]        SW,
  output logic [9:0]        LEDR
);

  typedef enum logic [2:0] {
    SEL_UNMAP,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCOUNT,
    SEL_TCTRL
  } sel_e;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  sel_e        region;
  sel_e        sel_q;
  logic [9:0]  led_q, led_d;
  logic [9:0]  sw_meta_q, sw_sync_q;
  logic [15:0] count_q, count_d;
  logic [15:0] pre_q, pre_d;
  logic        run_q, run_d;
  logic        wr_tcount, wr_tctrl;

  always_comb begin
    case (addr[15:12])
      4'h0:    region = SEL_RAM;
      4'h1:    region = SEL_LED;
      4'h3:    region = SEL_SW;
      4'h4:    region = SEL_TCOUNT;
      4'h5:    region = SEL_TCTRL;
      default: region = SEL_UNMAP;
    endcase
  end

  assign ram_address = addr[RAM_AW-1:0];
  assign ram_data    = dout;
  // Gated by Resetn so a stray strobe during reset cannot corrupt the RAM.
  assign ram_wren    = w & Resetn & (region == SEL_RAM);

  assign wr_tcount = w & (region == SEL_TCOUNT);
  assign wr_tctrl  = w & (region == SEL_TCTRL);

  always_comb begin
    led_d = led_q;
    if (w && region == SEL_LED) begin
      led_d = dout[9:0];
    end
  end

  // Any timer write suppresses that cycle's tick; a TCTRL clear wins over
  // everything, then a TCOUNT load, then the prescaled increment.
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    run_d   = run_q;
    if (wr_tctrl) begin
      run_d = dout[0];
      if (dout[1]) begin
        count_d = '0;
        pre_d   = '0;
      end
    end else if (wr_tcount) begin
      count_d = dout;
      pre_d   = '0;
    end else if (run_q) begin
      if (pre_q == PRE_LAST) begin
        pre_d   = '0;
        count_d = count_q + 16'd1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sel_q     <= SEL_UNMAP;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      count_q   <= '0;
      pre_q     <= '0;
      run_q     <= 1'b0;
    end else begin
      sel_q     <= region;
      led_q     <= led_d;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      count_q   <= count_d;
      pre_q     <= pre_d;
      run_q     <= run_d;
    end
  end

  always_comb begin
    case (sel_q)
      SEL_RAM:    DATA = ram_q;
      SEL_LED:    DATA = {6'b0, led_q};
      SEL_SW:     DATA = {6'b0, sw_sync_q};
      SEL_TCOUNT: DATA = count_q;
      SEL_TCTRL:  DATA = {15'b0, run_q};
      default:    DATA = 16'h0000;
    endcase
  end

  assign LEDR = led_q;

endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 Parameter RAM_AW, default 8: RAM address width; RAM depth is 2^RAM_AW words.
REQ-002 Parameter PRESCALE, default 50000: Clock cycles per timer tick, legal range 1..65535.
REQ-003 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 addr  input  16  processor ADDR register output; stable for at least one cycle per access.
REQ-006 dout  input  16  processor DOUT register output, the write data.
REQ-007 w  input  1  processor registered write strobe; one-cycle-high pulse per store.
REQ-008 DATA  output  16  read data returned to the processor bus mux.
REQ-009 ram_address  output  RAM_AW  address to the synchronous data RAM.
REQ-010 ram_data  output  16  write data to the RAM.
REQ-011 ram_wren  output  1  RAM write enable.
REQ-012 ram_q  input  16  RAM read data, valid one cycle after ram_address.
REQ-013 SW  input  10  asynchronous board switches.
REQ-014 LEDR  output  10  board LEDs.

Function
REQ-015 The bridge SHALL decode region = addr[15:12] as: 0x0 RAM, 0x1 LED, 0x3 SW, 0x4 TCOUNT, 0x5 TCTRL; any other value is UNMAPPED.
REQ-016 ram_address SHALL equal addr[RAM_AW-1:0] combinationally, and ram_data SHALL equal dout combinationally.
REQ-017 ram_wren SHALL equal w AND (region == RAM), combinationally; RAM addresses above 2^RAM_AW-1 alias by truncation.
REQ-018 On a rising edge with w=1 and region LED, LEDR SHALL load dout[9:0].
REQ-019 SW SHALL pass through a two-flop synchronizer; sw_sync SHALL reflect an SW change on the second rising edge after it.
REQ-020 Every rising edge SHALL capture the current region into sel_q, which is the registered read select.
REQ-021 DATA SHALL be a combinational function of sel_q only:
- RAM gives ram_q.
- LED gives {6'b0, LEDR}.
- SW gives {6'b0, sw_sync}.
- TCOUNT gives count.
- TCTRL gives {15'b0, run}.
- UNMAPPED gives 16'h0000.
REQ-022 Read latency SHALL be exactly one cycle: DATA is valid during the cycle after addr is presented, for all regions.
REQ-023 Timer state SHALL consist of a 16-bit count, a 16-bit prescaler counter pre, and a run bit.
REQ-024 When run=1, pre SHALL increment each cycle.
- When pre reaches PRESCALE-1 it SHALL return to 0 and count SHALL increment by 1.
- count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-025 When run=0, pre and count SHALL hold.
REQ-026 A write with region TCTRL SHALL set run to dout[0].
- If dout[1]=1, the same write SHALL also clear count and pre to 0.
- dout[1] is not stored and reads back as 0.
REQ-027 A write with region TCOUNT SHALL load count with dout and clear pre to 0.
REQ-028 Priority on a cycle with simultaneous events SHALL be: TCTRL clear, then TCOUNT load, then tick increment; a write always overrides that cycle's tick.
REQ-029 Writes with region UNMAPPED or SW SHALL be ignored, with no state change and ram_wren=0.
REQ-030 A read in the cycle after a write to the same LED, TCOUNT or TCTRL address SHALL return the newly written value.

Reset
REQ-031 Resetn=0 SHALL immediately force the following, independent of Clock:
- LEDR=0, count=0, pre=0, run=0.
- Both synchronizer stages = 0.
- sel_q=UNMAPPED, so DATA=16'h0000.
REQ-032 ram_wren SHALL be 0 while Resetn=0, regardless of w; RAM contents are not cleared.
REQ-033 Reset asserted mid-count SHALL stop the timer at 0; the timer stays stopped after release until TCTRL is written with run=1.

Verification
REQ-034 The bench SHALL cover each directed scenario below, with PRESCALE=4 and RAM_AW=8:
- RAM write/read: addr=16'h0012, dout=16'hBEEF, w pulse, then addr=16'h0012 for one cycle -> ram_wren high for one cycle; DATA=16'hBEEF the following cycle.
- LED: write 16'h03FF to 16'h1000 -> LEDR=10'h3FF next edge; read 16'h1000 -> DATA=16'h03FF.
- SW sync: SW changes to 10'h155 -> read 16'h3000 returns 16'h0155 no earlier than two edges later.
- Timer: write 16'h0001 to 16'h5000, wait 12 cycles -> count=3.
- Timer wrap and clear: write 16'hFFFF to 16'h4000 with run=1, wait 4 cycles -> count=0; then write 16'h0003 to 16'h5000 on a tick cycle -> count=0, run=1.
- Reset mid-operation: assert Resetn=0 while run=1 and LEDR=10'h2AA -> LEDR=0, count=0, DATA=0 at once; after release, count holds 0.
- Unmapped access: write 16'h1234 to 16'h7000 -> ram_wren=0, no state change; read 16'h7000 -> DATA=16'h0000.
